// File: rtl/adder_result_queue.sv
// Collects {cout, sum} results from the fixed-latency pipelined adder into a FWFT FIFO,
// with credit-based issue control. Define ADDER_RESULT_QUEUE_COUNT_EN to add pop_count_o.
module adder_result_queue #(
  parameter int unsigned width   = 32,
  parameter int unsigned latency = width / 8,
  parameter int unsigned depth   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [width-1:0]       sum_i,
  input  logic                   cout_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [width-1:0]       out_sum_o,
  output logic                   out_cout_o,
  output logic [$clog2(depth):0] level_o
`ifdef ADDER_RESULT_QUEUE_COUNT_EN
  ,
  output logic [31:0]            pop_count_o
`endif
);

  localparam int unsigned PW = $clog2(depth);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic             cout;
    logic [width-1:0] sum;
  } entry_t;

  entry_t             mem [depth];
  logic [latency-1:0] sr_q, sr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      level_q, level_d;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [CW:0]        credit_used;
  logic               issue;
  logic               push;
  logic               pop;

  // Handshakes and head presentation, all derived from registered state.
  always_comb begin
    credit_used = (CW+1)'(level_q) + (CW+1)'(inflight_q);
    in_ready_o  = !rst_i && (credit_used < (CW+1)'(depth));
    issue       = in_valid_i && in_ready_o;
    push        = sr_q[latency-1];
    out_valid_o = (level_q != '0);
    pop         = out_valid_o && out_ready_i;
    out_sum_o   = out_valid_o ? mem[rd_ptr_q].sum  : '0;
    out_cout_o  = out_valid_o ? mem[rd_ptr_q].cout : 1'b0;
    level_o     = level_q;
  end

  // Next-state: issue tracking, pointers, occupancy and in-flight credits.
  always_comb begin
    sr_d       = sr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    inflight_d = inflight_q;

    sr_d       = (sr_q << 1) | latency'(issue);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    level_d    = level_q + CW'(push) - CW'(pop);
    inflight_d = inflight_q + CW'(issue) - CW'(push);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      inflight_q <= '0;
    end else begin
      sr_q       <= sr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
    end
  end

  // Storage is not reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= {cout_i, sum_i};
    end
  end

`ifdef ADDER_RESULT_QUEUE_COUNT_EN
  logic [31:0] pop_count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pop_count_q <= '0;
    end else begin
      pop_count_q <= pop_count_q + 32'(pop);
    end
  end

  assign pop_count_o = pop_count_q;
`endif

endmodule

// File: tb/tb_adder_result_queue.sv
// Bench for adder_result_queue (width=16, latency=2, depth=4): an adder model feeds sum_i,
// and a queue-level reference model predicts every output on every cycle.
module tb_adder_result_queue;

  localparam int unsigned W   = 16;
  localparam int unsigned LAT = 2;
  localparam int unsigned DEP = 4;

  logic          clk;
  logic          rst_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [W-1:0]  sum_i;
  logic          cout_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [W-1:0]  out_sum_o;
  logic          out_cout_o;
  logic [2:0]    level_o;
`ifdef ADDER_RESULT_QUEUE_COUNT_EN
  logic [31:0]   pop_count_o;
`endif

  adder_result_queue #(.width(W), .latency(LAT), .depth(DEP)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .sum_i       (sum_i),
    .cout_i      (cout_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_sum_o   (out_sum_o),
    .out_cout_o  (out_cout_o),
    .level_o     (level_o)
`ifdef ADDER_RESULT_QUEUE_COUNT_EN
    ,
    .pop_count_o (pop_count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [16:0] val;
  } flight_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_cin;
  logic [16:0] vals [0:8191];
  logic [16:0] eq [$];
  flight_t     fl [$];
  logic [31:0] pops = 0;

  logic        s_ready, s_valid, s_cout;
  logic [15:0] s_sum;
  logic [2:0]  s_level;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, got, exp);
    end
  endtask

  // Compare every observable output against the reference model.
  task automatic check_model();
    logic [16:0] head;
    logic        m_ready;
    head    = (eq.size() > 0) ? eq[0] : 17'h0;
    m_ready = !rst_i && ((eq.size() + fl.size()) < DEP);
    check("in_ready",  32'(in_ready_o),  32'(m_ready));
    check("out_valid", 32'(out_valid_o), 32'(eq.size() > 0));
    check("out_sum",   32'(out_sum_o),   32'(head[15:0]));
    check("out_cout",  32'(out_cout_o),  32'(head[16]));
    check("level",     32'(level_o),     32'(eq.size()));
`ifdef ADDER_RESULT_QUEUE_COUNT_EN
    check("pop_count", pop_count_o, pops);
`endif
  endtask

  task automatic model_update();
    logic    m_ready, m_issue, m_pop, m_push;
    flight_t f;
    if (rst_i) begin
      eq.delete();
      fl.delete();
      pops = 0;
    end else begin
      m_ready = (eq.size() + fl.size()) < DEP;
      m_issue = in_valid_i && m_ready;
      m_pop   = (eq.size() > 0) && out_ready_i;
      m_push  = (fl.size() > 0) && (fl[0].due == cyc);
      if (m_pop) begin
        void'(eq.pop_front());
        pops = pops + 1;
      end
      if (m_push) begin
        f = fl.pop_front();
        eq.push_back(f.val);
      end
      if (m_issue) begin
        f.due = cyc + LAT;
        f.val = vals[cyc];
        fl.push_back(f);
      end
    end
  endtask

  // One clock cycle: adder model drives sum_i, outputs checked mid-cycle, model stepped at the edge.
  task automatic tick();
    vals[cyc] = 17'(op_a) + 17'(op_b) + 17'(op_cin);
    if (cyc >= LAT) begin
      {cout_i, sum_i} = vals[cyc-LAT];
    end else begin
      {cout_i, sum_i} = 17'($urandom);
    end
    @(negedge clk);
    check_model();
    s_ready = in_ready_o;
    s_valid = out_valid_o;
    s_sum   = out_sum_o;
    s_cout  = out_cout_o;
    s_level = level_o;
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic idle_ops();
    op_a   = 16'($urandom);
    op_b   = 16'($urandom);
    op_cin = 1'($urandom);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    idle_ops();
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    op_a = '0;
    op_b = '0;
    op_cin = 1'b0;

    // Reset state
    do_reset();
    check("rst_level", 32'(s_level), 32'd0);
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);

    // Single result
    do_reset();
    in_valid_i = 1'b1; op_a = 16'h1234; op_b = 16'h0101; op_cin = 1'b0;
    tick();
    check("t1_ready0", 32'(s_ready), 32'd1);
    in_valid_i = 1'b0;
    idle_ops(); tick();
    idle_ops(); tick();
    out_ready_i = 1'b1;
    idle_ops(); tick();
    check("t1_valid3", 32'(s_valid), 32'd1);
    check("t1_sum3",   32'(s_sum),   32'h1335);
    check("t1_cout3",  32'(s_cout),  32'd0);
    idle_ops(); tick();
    check("t1_valid4", 32'(s_valid), 32'd0);

    // Backpressure fill, then drain in order
    do_reset();
    out_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid_i = 1'b1;
      op_a = 16'(k) << 8; op_b = 16'(k); op_cin = 1'b0;
      tick();
      if (k == 4) check("t2_ready4", 32'(s_ready), 32'd0);
    end
    in_valid_i = 1'b0;
    idle_ops(); tick();
    check("t2_level6", 32'(s_level), 32'd4);
    out_ready_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      idle_ops(); tick();
      check("t3_valid", 32'(s_valid), 32'd1);
      check("t3_order", 32'(s_sum), 32'(j * 257));
      if (j == 1) check("t3_credit", 32'(s_ready), 32'd1);
    end
    idle_ops(); tick();
    check("t3_empty", 32'(s_valid), 32'd0);

    // Carry out, then a stream long enough to wrap the pointers
    do_reset();
    in_valid_i = 1'b1; op_a = 16'hFFFF; op_b = 16'h0001; op_cin = 1'b0;
    tick();
    in_valid_i = 1'b0;
    idle_ops(); tick();
    idle_ops(); tick();
    out_ready_i = 1'b1;
    idle_ops(); tick();
    check("t4_sum",  32'(s_sum),  32'h0000);
    check("t4_cout", 32'(s_cout), 32'd1);
    for (int j = 0; j < 10; j++) begin
      in_valid_i = 1'b1; idle_ops(); tick();
    end
    in_valid_i = 1'b0;
    for (int j = 0; j < 5; j++) begin
      idle_ops(); tick();
    end

    // Reset mid-flight discards tracked issues
    do_reset();
    in_valid_i = 1'b1; idle_ops(); tick();
    idle_ops(); tick();
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      if (k == 4) rst_i = 1'b0;
      idle_ops(); tick();
      check("t5_valid", 32'(s_valid), 32'd0);
      check("t5_level", 32'(s_level), 32'd0);
    end

    // Simultaneous push and pop at level 2
    do_reset();
    out_ready_i = 1'b0;
    in_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle_ops(); tick();
    end
    in_valid_i = 1'b0;
    idle_ops(); tick();
    out_ready_i = 1'b1;
    idle_ops(); tick();
    check("t6_level_pre",  32'(s_level), 32'd2);
    idle_ops(); tick();
    check("t6_level_post", 32'(s_level), 32'd2);
    for (int j = 0; j < 4; j++) begin
      idle_ops(); tick();
    end

    // Randomized traffic with bursts of backpressure and rare resets
    for (int n = 0; n < 1500; n++) begin
      rst_i       = ($urandom_range(0, 299) == 0);
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ((n / 40) % 3 == 1) ? ($urandom_range(0, 4) == 0)
                                         : ($urandom_range(0, 2) != 0);
      idle_ops();
      tick();
    end
    rst_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
